// File: rtl/fp16_pkg.sv
// Shared binary16 constants, rounding-mode encoding and divider state type.
// Imported by the divider and rounding blocks.
package fp16_pkg;

  localparam int unsigned ExpW  = 5;
  localparam int unsigned FracW = 10;
  localparam int unsigned Bias  = 15;
  localparam int unsigned QBits = 13;

  localparam logic [1:0] RZ  = 2'b00;
  localparam logic [1:0] RNE = 2'b01;
  localparam logic [1:0] RP  = 2'b10;
  localparam logic [1:0] RN  = 2'b11;

  localparam logic [15:0] QNAN = 16'h7E00;
  localparam logic [15:0] INF  = 16'h7C00;
  localparam logic [15:0] MAXF = 16'h7BFF;

  // Bit positions within flags = {nv, dz, of, uf, nx}
  localparam int unsigned FlagNv = 4;
  localparam int unsigned FlagDz = 3;
  localparam int unsigned FlagOf = 2;
  localparam int unsigned FlagUf = 1;
  localparam int unsigned FlagNx = 0;

  typedef enum logic [1:0] {StIdle, StDiv, StRound, StDone} state_e;

endpackage

// File: rtl/fp16_round.sv
// Combinational binary16 rounding: normalised mantissa plus guard/sticky in,
// packed result with overflow/underflow/inexact out. Subnormal results flush to zero.
module fp16_round
  import fp16_pkg::*;
(
  input  logic              sign,
  input  logic [10:0]       mant,
  input  logic              guard,
  input  logic              sticky,
  input  logic signed [6:0] exp,
  input  logic [1:0]        roundmode,
  output logic [15:0]       result,
  output logic              of,
  output logic              uf,
  output logic              nx
);

  logic              lost;
  logic              inc;
  logic [11:0]       sum;
  logic [10:0]       mant_r;
  logic signed [6:0] exp_r;
  logic              to_zero;

  always_comb begin
    lost = guard | sticky;
    unique case (roundmode)
      RZ:      inc = 1'b0;
      RNE:     inc = guard & (sticky | mant[0]);
      RP:      inc = ~sign & lost;
      default: inc = sign & lost;
    endcase

    sum = {1'b0, mant} + {11'd0, inc};
    if (sum[11]) begin
      mant_r = 11'h400;
      exp_r  = exp + 7'sd1;
    end else begin
      mant_r = sum[10:0];
      exp_r  = exp;
    end

    // Modes that never round away from zero saturate to max finite instead of inf
    to_zero = (roundmode == RZ) || (roundmode == RP && sign) || (roundmode == RN && !sign);

    of     = 1'b0;
    uf     = 1'b0;
    nx     = lost;
    result = {sign, exp_r[4:0], mant_r[9:0]};
    if (exp_r >= 7'sd31) begin
      of     = 1'b1;
      nx     = 1'b1;
      result = to_zero ? {sign, MAXF[14:0]} : {sign, INF[14:0]};
    end else if (exp_r <= 7'sd0) begin
      uf     = 1'b1;
      nx     = 1'b1;
      result = {sign, 15'd0};
    end
  end

endmodule

// File: rtl/fdiv16.sv
// Iterative binary16 divider: restoring radix-2, one quotient bit per cycle,
// valid/ready handshakes on both sides, single operation in flight.
module fdiv16
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [1:0]  roundmode,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] result,
  output logic [4:0]  flags,
  output logic        out_valid,
  input  logic        out_ready
);

  state_e            state_q, state_d;
  logic [3:0]        counter_q, counter_d;
  logic              sign_q, sign_d;
  logic [10:0]       my_q, my_d;
  logic [11:0]       rem_q, rem_d;
  logic [12:0]       q_q, q_d;
  logic signed [6:0] exp_q, exp_d;
  logic [1:0]        rm_q, rm_d;
  logic [15:0]       result_q, result_d;
  logic [4:0]        flags_q, flags_d;

  logic [4:0]        x_exp, y_exp;
  logic              x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, special;
  logic signed [6:0] exp_in;
  logic [15:0]       spec_res;
  logic [4:0]        spec_flags;

  // Subnormal inputs (exp == 0) are treated as zero
  assign x_exp   = x[14:10];
  assign y_exp   = y[14:10];
  assign x_zero  = (x_exp == 5'd0);
  assign y_zero  = (y_exp == 5'd0);
  assign x_nan   = (x_exp == 5'd31) && (x[9:0] != 10'd0);
  assign y_nan   = (y_exp == 5'd31) && (y[9:0] != 10'd0);
  assign x_inf   = (x_exp == 5'd31) && (x[9:0] == 10'd0);
  assign y_inf   = (y_exp == 5'd31) && (y[9:0] == 10'd0);
  assign special = x_zero | y_zero | x_inf | y_inf | x_nan | y_nan;
  assign exp_in  = $signed({2'b00, x_exp}) - $signed({2'b00, y_exp}) + 7'sd15;

  always_comb begin
    spec_res   = {x[15] ^ y[15], 15'd0};
    spec_flags = '0;
    if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
      spec_res           = QNAN;
      spec_flags[FlagNv] = 1'b1;
    end else if (y_zero && !x_inf) begin
      spec_res           = {x[15] ^ y[15], INF[14:0]};
      spec_flags[FlagDz] = 1'b1;
    end else if (x_inf) begin
      spec_res = {x[15] ^ y[15], INF[14:0]};
    end
  end

  logic              norm_hi;
  logic [10:0]       mant_n;
  logic              guard_n, sticky_n;
  logic signed [6:0] exp_n;
  logic [15:0]       rnd_result;
  logic              rnd_of, rnd_uf, rnd_nx;

  assign norm_hi  = q_q[12];
  assign mant_n   = norm_hi ? q_q[12:2] : q_q[11:1];
  assign guard_n  = norm_hi ? q_q[1] : q_q[0];
  assign sticky_n = (norm_hi & q_q[0]) | (rem_q != 12'd0);
  assign exp_n    = norm_hi ? exp_q : exp_q - 7'sd1;

  fp16_round u_round (
    .sign      (sign_q),
    .mant      (mant_n),
    .guard     (guard_n),
    .sticky    (sticky_n),
    .exp       (exp_n),
    .roundmode (rm_q),
    .result    (rnd_result),
    .of        (rnd_of),
    .uf        (rnd_uf),
    .nx        (rnd_nx)
  );

  logic        rem_ge;
  logic [11:0] rem_diff;

  assign rem_ge   = (rem_q >= {1'b0, my_q});
  assign rem_diff = rem_ge ? rem_q - {1'b0, my_q} : rem_q;

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    sign_d    = sign_q;
    my_d      = my_q;
    rem_d     = rem_q;
    q_d       = q_q;
    exp_d     = exp_q;
    rm_d      = rm_q;
    result_d  = result_q;
    flags_d   = flags_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d = x[15] ^ y[15];
          my_d   = {1'b1, y[9:0]};
          exp_d  = exp_in;
          rm_d   = roundmode;
          if (special) begin
            result_d = spec_res;
            flags_d  = spec_flags;
            state_d  = StDone;
          end else begin
            rem_d     = {1'b0, 1'b1, x[9:0]};
            q_d       = '0;
            counter_d = '0;
            state_d   = StDiv;
          end
        end
      end
      StDiv: begin
        // Remainder stays below 2*my, so the shifted value always fits 12 bits
        rem_d     = {rem_diff[10:0], 1'b0};
        q_d       = {q_q[11:0], rem_ge};
        counter_d = counter_q + 4'd1;
        if (counter_q == 4'(QBits - 1)) state_d = StRound;
      end
      StRound: begin
        result_d         = rnd_result;
        flags_d          = '0;
        flags_d[FlagOf]  = rnd_of;
        flags_d[FlagUf]  = rnd_uf;
        flags_d[FlagNx]  = rnd_nx;
        state_d          = StDone;
      end
      default: begin
        if (out_ready) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      counter_q <= '0;
      sign_q    <= 1'b0;
      my_q      <= '0;
      rem_q     <= '0;
      q_q       <= '0;
      exp_q     <= '0;
      rm_q      <= '0;
      result_q  <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      sign_q    <= sign_d;
      my_q      <= my_d;
      rem_q     <= rem_d;
      q_q       <= q_d;
      exp_q     <= exp_d;
      rm_q      <= rm_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fdiv16.sv
// Directed self-checking bench for fdiv16: rounding modes, specials,
// overflow/underflow, output back-pressure and reset mid-division.
module tb_fdiv16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] x, y;
  logic [1:0]  roundmode;
  logic        in_valid, in_ready;
  logic [15:0] result;
  logic [4:0]  flags;
  logic        out_valid, out_ready;

  int checks = 0;
  int passed = 0;
  int edges;
  int seen_valid;

  fdiv16 dut (
    .clk       (clk),
    .reset     (reset),
    .x         (x),
    .y         (y),
    .roundmode (roundmode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .flags     (flags),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one operation; edges counts rising edges from the accepting edge (1) to out_valid
  task automatic do_op(input logic [15:0] xa, input logic [15:0] ya, input logic [1:0] rm,
                       output int n);
    @(negedge clk);
    x = xa;
    y = ya;
    roundmode = rm;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) begin
      checks++;
      $error("FAIL wait_out_valid: timed out after %0d edges", n);
    end
  endtask

  task automatic release_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    x = '0;
    y = '0;
    roundmode = 2'b01;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 16'h0000);
    check("rst_flags", flags, 5'b00000);
    @(negedge clk);
    reset = 1'b0;

    do_op(16'h3C00, 16'h3C00, 2'b01, edges);
    check("one_lat", edges, 15);
    check("one_res", result, 16'h3C00);
    check("one_flags", flags, 5'b00000);
    release_op();

    do_op(16'h3C00, 16'h4200, 2'b01, edges);
    check("third_rne_res", result, 16'h3555);
    check("third_rne_flags", flags, 5'b00001);
    release_op();
    do_op(16'h3C00, 16'h4200, 2'b10, edges);
    check("third_rp_res", result, 16'h3556);
    release_op();
    do_op(16'h3C00, 16'h4200, 2'b00, edges);
    check("third_rz_res", result, 16'h3555);
    release_op();
    do_op(16'h3C00, 16'h4200, 2'b11, edges);
    check("third_rn_res", result, 16'h3555);
    release_op();

    do_op(16'hC600, 16'h4000, 2'b01, edges);
    check("neg_res", result, 16'hC200);
    check("neg_flags", flags, 5'b00000);
    release_op();

    do_op(16'h3C00, 16'h0000, 2'b01, edges);
    check("dz_lat", edges, 1);
    check("dz_res", result, 16'h7C00);
    check("dz_flags", flags, 5'b01000);
    release_op();
    do_op(16'h0000, 16'h0000, 2'b01, edges);
    check("nv_lat", edges, 1);
    check("nv_res", result, 16'h7E00);
    check("nv_flags", flags, 5'b10000);
    release_op();
    do_op(16'h7C00, 16'h3C00, 2'b01, edges);
    check("inf_lat", edges, 1);
    check("inf_res", result, 16'h7C00);
    check("inf_flags", flags, 5'b00000);
    release_op();

    do_op(16'h7BFF, 16'h1400, 2'b01, edges);
    check("of_rne_res", result, 16'h7C00);
    check("of_rne_flags", flags, 5'b00101);
    release_op();
    do_op(16'h7BFF, 16'h1400, 2'b00, edges);
    check("of_rz_res", result, 16'h7BFF);
    check("of_rz_flags", flags, 5'b00101);
    release_op();

    do_op(16'h0400, 16'h7800, 2'b01, edges);
    check("uf_res", result, 16'h0000);
    check("uf_flags", flags, 5'b00011);
    release_op();

    // Back-pressure: result must hold while out_ready stays low
    do_op(16'hC600, 16'h4000, 2'b01, edges);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_res", result, 16'hC200);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_out_valid", out_valid, 1'b1);
    end
    release_op();
    check("post_release_in_ready", in_ready, 1'b1);

    // Reset in the middle of a division
    @(negedge clk);
    x = 16'h3C00;
    y = 16'h4200;
    roundmode = 2'b01;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_result", result, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    seen_valid = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) seen_valid++;
    end
    check("no_stale_valid", seen_valid, 0);
    check("no_stale_result", result, 16'h0000);

    do_op(16'h3C00, 16'h3C00, 2'b01, edges);
    check("after_rst_lat", edges, 15);
    check("after_rst_res", result, 16'h3C00);
    release_op();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
